// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit ripple-carry adder among NREQ requesters.
// Optional saturation of the returned sum on signed overflow: define ADDER_ARB_SAT_EN.

module ripple_carry_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic               busy,
    output logic [1:0]         dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // a producer keeps valid and its payload stable until then, ready may depend on valid.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] last_grant, grant_idx, id_q;
    logic           grant_found, accept;
    logic [31:0]    sel_a, sel_b, a_q, b_q, add_sum, sum_final;
    logic           sel_cin, cin_q, add_cout, ovf;

    // Two passes: indices above last_grant first, then wrap around to the rest.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_cin     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && (i > int'(last_grant)) && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
                sel_a       = req_a[32*i +: 32];
                sel_b       = req_b[32*i +: 32];
                sel_cin     = req_cin[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && (i <= int'(last_grant)) && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
                sel_a       = req_a[32*i +: 32];
                sel_b       = req_b[32*i +: 32];
                sel_cin     = req_cin[i];
            end
        end
    end

    ripple_carry_adder u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign ovf = (a_q[31] == b_q[31]) && (add_sum[31] != a_q[31]);

`ifdef ADDER_ARB_SAT_EN
    assign sum_final = ovf ? (a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : add_sum;
`else
    assign sum_final = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // rst_n gates the grant so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == IDLE) && grant_found && rst_n && (grant_idx == IDW'(i));
        end
        busy      = (state != IDLE);
        dbg_state = state;
    end

    assign accept = |(req_ready & req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= sel_a;
                b_q   <= sel_b;
                cin_q <= sel_cin;
                id_q  <= grant_idx;
            end
            if (state == CALC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                rsp_sum   <= sum_final;
                rsp_cout  <= add_cout;
                rsp_ovf   <= ovf;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
                last_grant <= rsp_id;
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, arithmetic vectors, round-robin order,
// backpressure and reset mid-operation. Define ADDER_ARB_SAT_EN to check saturation.

module tb_adder_arbiter;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic         busy;
    logic [1:0]   dbg_state;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    adder_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_cin[r]        = cin;
    endtask

    function automatic logic [31:0] sat_exp(input logic [31:0] raw, input logic [31:0] a, input logic ovf);
`ifdef ADDER_ARB_SAT_EN
        if (ovf) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return raw;
    endfunction

    // Starts and ends just after a rising edge with the DUT in IDLE.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic [31:0] raw, input logic ecout, input logic eovf);
        logic [3:0] one;
        one = 4'b0001 << r;
        set_req(r, a, b, cin);
        req_valid[r] = 1'b1;
        #1;
        check("op_grant", {28'd0, req_ready}, {28'd0, one});
        tick();
        req_valid[r] = 1'b0;
        check("op_calc_valid", {31'd0, rsp_valid}, 32'd0);
        check("op_calc_busy", {31'd0, busy}, 32'd1);
        tick();
        check("op_valid", {31'd0, rsp_valid}, 32'd1);
        check("op_sum", rsp_sum, sat_exp(raw, a, eovf));
        check("op_cout", {31'd0, rsp_cout}, {31'd0, ecout});
        check("op_ovf", {31'd0, rsp_ovf}, {31'd0, eovf});
        check("op_id", {30'd0, rsp_id}, r);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("op_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("op_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] id;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        rsp_ready    = 1'b0;
        req_valid    = 4'h0;
        req_a        = '0;
        req_b        = '0;
        req_cin      = '0;
        for (int i = 0; i < 4; i++) set_req(i, 32'h100 * i + 7, 32'h10, 1'b0);
        req_valid = 4'hF;

        // Reset state, with every requester asking.
        tick();
        tick();
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", rsp_sum, 32'd0);
        check("rst_id", {30'd0, rsp_id}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rr_first_grant", {28'd0, req_ready}, 32'h1);

        // Round-robin with all requesters held valid.
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!rsp_valid && n < 10) begin
                tick();
                n++;
            end
            check("rr_timeout", {31'd0, (n < 10)}, 32'd1);
            id = exp_q.pop_front();
            check("rr_id", {30'd0, rsp_id}, id);
            check("rr_sum", rsp_sum, 32'h100 * id + 32'h17);
            tick();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        check("rr_end_valid", {31'd0, rsp_valid}, 32'd0);

        // Arithmetic vectors with hand-computed raw sums.
        run_op(0, 32'd50,        32'd100,     1'b0, 32'd150,       1'b0, 1'b0);
        run_op(1, 32'h7FFF_FFFF, 32'd1,       1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op(2, 32'hFFFF_FFCE, 32'hFFFF_FF9C, 1'b1, 32'hFFFF_FF6B, 1'b1, 1'b0);
        run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op(0, 32'hFFFF_FFFF, 32'd0,       1'b1, 32'd0,         1'b1, 1'b0);
        run_op(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0);

        // Backpressure: requester 3 held in RESP while requester 0 waits.
        set_req(3, 32'd5, 32'd6, 1'b0);
        set_req(0, 32'h10, 32'h20, 1'b1);
        req_valid[3] = 1'b1;
        #1;
        check("bp_grant", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid[3] = 1'b0;
        req_valid[0] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_sum", rsp_sum, 32'd11);
            check("bp_id", {30'd0, rsp_id}, 32'd3);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_next_grant", {28'd0, req_ready}, 32'h1);
        req_valid[0] = 1'b0;
        tick();
        check("idle_no_req", {28'd0, req_ready}, 32'd0);
        check("idle_state", {30'd0, dbg_state}, 32'd0);

        // Reset during CALC for requester 2 drops the result.
        set_req(2, 32'd1, 32'd2, 1'b0);
        req_valid[2] = 1'b1;
        #1;
        check("mr_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b0101;
        check("mr_calc_state", {30'd0, dbg_state}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_req_ready", {28'd0, req_ready}, 32'd0);
        check("mr_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_first_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("mr_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("mr_rsp_sum", rsp_sum, 32'h31);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("mr_next_grant", {28'd0, req_ready}, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
